// File: rtl/cpu_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_control_unit
//  Purpose  : Multi-cycle FETCH/DECODE/EXECUTE sequencer that drives every
//             control pin of the CPU execution unit and the memory strobes.
//             Optional macro CPU_CU_SINGLE_STEP_EN adds a 'step' input that
//             gates each instruction fetch.
//  Revision : 1.0  initial release
// ============================================================================
module cpu_control_unit #(
    parameter logic [3:0] ALU_PASS_S = 4'h0,
    parameter logic [3:0] ALU_PASS_R = 4'h1
) (
    input  logic        clk,
    input  logic        reset,
`ifdef CPU_CU_SINGLE_STEP_EN
    input  logic        step,
`endif
    input  logic [15:0] IR,
    input  logic        C,
    input  logic        N,
    input  logic        Z,
    output logic        W_En,
    output logic [2:0]  W_Adr,
    output logic [2:0]  R_Adr,
    output logic [2:0]  S_Adr,
    output logic        sel,
    output logic [3:0]  alu_op,
    output logic        adr_sel,
    output logic        ld_en,
    output logic        pc_inc,
    output logic        pc_sel,
    output logic        ir_en,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        halted,
    output logic [2:0]  flags
);

    localparam logic [3:0] c_OP_ALU  = 4'h0;
    localparam logic [3:0] c_OP_LD   = 4'h1;
    localparam logic [3:0] c_OP_ST   = 4'h2;
    localparam logic [3:0] c_OP_JMP  = 4'h3;
    localparam logic [3:0] c_OP_BR   = 4'h4;
    localparam logic [3:0] c_OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_DECODE   = 3'd1,
        ST_EXEC_ALU = 3'd2,
        ST_LOAD     = 3'd3,
        ST_STORE    = 3'd4,
        ST_JUMP     = 3'd5,
        ST_BRANCH   = 3'd6,
        ST_HALT     = 3'd7
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [2:0] r_flags;

    logic [3:0] w_op;
    logic [3:0] w_fn;
    logic [2:0] w_wfld;
    logic [2:0] w_rfld;
    logic [2:0] w_sfld;
    logic       w_go;
    logic       w_br_taken;

    assign w_op   = IR[15:12];
    assign w_fn   = IR[11:8];
    assign w_wfld = IR[8:6];
    assign w_rfld = IR[5:3];
    assign w_sfld = IR[2:0];

`ifdef CPU_CU_SINGLE_STEP_EN
    assign w_go = step;
`else
    assign w_go = 1'b1;
`endif

    // r_flags is {CF, NF, ZF}
    always_comb begin
        w_br_taken = 1'b0;
        case (w_fn)
            4'h0:    w_br_taken = 1'b1;
            4'h1:    w_br_taken = r_flags[0];
            4'h2:    w_br_taken = ~r_flags[0];
            4'h3:    w_br_taken = r_flags[2];
            4'h4:    w_br_taken = ~r_flags[2];
            4'h5:    w_br_taken = r_flags[1];
            4'h6:    w_br_taken = ~r_flags[1];
            default: w_br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
            r_flags <= 3'b000;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_EXEC_ALU) begin
                r_flags <= {C, N, Z};
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FETCH: begin
                if (w_go) begin
                    w_next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (w_op)
                    c_OP_ALU:  w_next_state = ST_EXEC_ALU;
                    c_OP_LD:   w_next_state = ST_LOAD;
                    c_OP_ST:   w_next_state = ST_STORE;
                    c_OP_JMP:  w_next_state = ST_JUMP;
                    c_OP_BR:   w_next_state = ST_BRANCH;
                    c_OP_HALT: w_next_state = ST_HALT;
                    default:   w_next_state = ST_HALT;
                endcase
            end
            ST_EXEC_ALU,
            ST_LOAD,
            ST_STORE,
            ST_JUMP,
            ST_BRANCH: w_next_state = ST_FETCH;
            ST_HALT:   w_next_state = ST_HALT;
            default:   w_next_state = ST_FETCH;
        endcase
    end

    // Reset gates every output so an aborted instruction writes nothing.
    always_comb begin
        W_En    = 1'b0;
        W_Adr   = 3'd0;
        R_Adr   = 3'd0;
        S_Adr   = 3'd0;
        sel     = 1'b0;
        alu_op  = ALU_PASS_R;
        adr_sel = 1'b0;
        ld_en   = 1'b0;
        pc_inc  = 1'b0;
        pc_sel  = 1'b0;
        ir_en   = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        halted  = 1'b0;
        flags   = 3'b000;
        if (!reset) begin
            flags = r_flags;
            case (r_state)
                ST_FETCH: begin
                    if (w_go) begin
                        mem_rd = 1'b1;
                        ir_en  = 1'b1;
                        pc_inc = 1'b1;
                    end
                end
                ST_EXEC_ALU: begin
                    W_En   = 1'b1;
                    W_Adr  = w_wfld;
                    R_Adr  = w_rfld;
                    S_Adr  = w_sfld;
                    alu_op = w_fn;
                end
                ST_LOAD: begin
                    W_En    = 1'b1;
                    W_Adr   = w_wfld;
                    R_Adr   = w_rfld;
                    sel     = 1'b1;
                    adr_sel = 1'b1;
                    mem_rd  = 1'b1;
                end
                ST_STORE: begin
                    R_Adr   = w_rfld;
                    S_Adr   = w_sfld;
                    alu_op  = ALU_PASS_S;
                    adr_sel = 1'b1;
                    mem_wr  = 1'b1;
                end
                ST_JUMP: begin
                    S_Adr  = w_sfld;
                    alu_op = ALU_PASS_S;
                    pc_sel = 1'b1;
                    ld_en  = 1'b1;
                end
                ST_BRANCH: begin
                    ld_en = w_br_taken;
                end
                ST_HALT: begin
                    halted = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_control_unit
//  Purpose  : Directed self-checking bench for cpu_control_unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu_control_unit;

    logic        clk;
    logic        reset;
    logic [15:0] IR;
    logic        C, N, Z;
    logic        W_En, sel, adr_sel, ld_en, pc_inc, pc_sel, ir_en;
    logic        mem_rd, mem_wr, halted;
    logic [2:0]  W_Adr, R_Adr, S_Adr, flags;
    logic [3:0]  alu_op;
`ifdef CPU_CU_SINGLE_STEP_EN
    logic        step;
`endif

    int          n_cmp;
    int          n_err;
    logic [2:0]  exp_flags;

    cpu_control_unit #(.ALU_PASS_S(4'h0), .ALU_PASS_R(4'h1)) dut (
        .clk     (clk),
        .reset   (reset),
`ifdef CPU_CU_SINGLE_STEP_EN
        .step    (step),
`endif
        .IR      (IR),
        .C       (C),
        .N       (N),
        .Z       (Z),
        .W_En    (W_En),
        .W_Adr   (W_Adr),
        .R_Adr   (R_Adr),
        .S_Adr   (S_Adr),
        .sel     (sel),
        .alu_op  (alu_op),
        .adr_sel (adr_sel),
        .ld_en   (ld_en),
        .pc_inc  (pc_inc),
        .pc_sel  (pc_sel),
        .ir_en   (ir_en),
        .mem_rd  (mem_rd),
        .mem_wr  (mem_wr),
        .halted  (halted),
        .flags   (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Expected pin bundle: {W_En,W_Adr,R_Adr,S_Adr,sel,alu_op,adr_sel,ld_en,pc_inc,pc_sel,ir_en,mem_rd,mem_wr,halted}
    function automatic logic [22:0] ev(input logic we, input logic [2:0] wa, input logic [2:0] ra,
                                       input logic [2:0] sa, input logic sl, input logic [3:0] op,
                                       input logic as, input logic ld, input logic inc, input logic ps,
                                       input logic ir, input logic rd, input logic wr, input logic hl);
        return {we, wa, ra, sa, sl, op, as, ld, inc, ps, ir, rd, wr, hl};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [22:0] exp_pins);
        logic [25:0] obs;
        logic [25:0] exp_all;
        #1;
        obs     = {W_En, W_Adr, R_Adr, S_Adr, sel, alu_op, adr_sel, ld_en, pc_inc, pc_sel,
                   ir_en, mem_rd, mem_wr, halted, flags};
        exp_all = {exp_pins, exp_flags};
        n_cmp++;
        assert (obs === exp_all) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_all);
        end
    endtask

    logic [22:0] e_idle, e_fetch, e_halt;

    // Runs one branch instruction and checks the taken/not-taken decision.
    task automatic run_branch(input string tag, input logic [15:0] instr, input logic taken);
        IR = instr;
        chk({tag, "_fetch"}, e_fetch);
        cyc();
        chk({tag, "_decode"}, e_idle);
        cyc();
        chk(tag, ev(0,0,0,0,0,4'h1,0,taken,0,0,0,0,0,0));
        cyc();
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        exp_flags = 3'b000;
        e_idle    = ev(0,0,0,0,0,4'h1,0,0,0,0,0,0,0,0);
        e_fetch   = ev(0,0,0,0,0,4'h1,0,0,1,0,1,1,0,0);
        e_halt    = ev(0,0,0,0,0,4'h1,0,0,0,0,0,0,0,1);
        reset     = 1'b1;
        IR        = 16'h029D;
        {C, N, Z} = 3'b111;
`ifdef CPU_CU_SINGLE_STEP_EN
        step      = 1'b1;
`endif

        // Reset held two clocks
        cyc();
        chk("reset_1", e_idle);
        cyc();
        chk("reset_2", e_idle);
        reset = 1'b0;

        // ALU add W=2 R=3 S=5, EU flags C=1 N=0 Z=1
        IR = 16'h029D;
        chk("alu_fetch", e_fetch);
        cyc();
        chk("alu_decode", e_idle);
        cyc();
        {C, N, Z} = 3'b101;
        chk("alu_exec", ev(1,3'd2,3'd3,3'd5,0,4'h2,0,0,0,0,0,0,0,0));
        cyc();
        exp_flags = 3'b101;

        // LD W=4 R=6; EU flags change but must not be latched
        IR = 16'h1130;
        chk("ld_fetch", e_fetch);
        cyc();
        chk("ld_decode", e_idle);
        cyc();
        {C, N, Z} = 3'b000;
        chk("ld_exec", ev(1,3'd4,3'd6,3'd0,1,4'h1,1,0,0,0,0,1,0,0));
        cyc();

        // ST R=1 S=7
        IR = 16'h200F;
        chk("st_fetch", e_fetch);
        cyc();
        chk("st_decode", e_idle);
        cyc();
        chk("st_exec", ev(0,3'd0,3'd1,3'd7,0,4'h0,1,0,0,0,0,0,1,0));
        cyc();

        // JMP S=3
        IR = 16'h3003;
        chk("jmp_fetch", e_fetch);
        cyc();
        chk("jmp_decode", e_idle);
        cyc();
        chk("jmp_exec", ev(0,3'd0,3'd0,3'd3,0,4'h0,0,1,0,1,0,0,0,0));
        cyc();

        // Branches against flags {CF,NF,ZF}=101
        run_branch("br_z_taken", 16'h41FE, 1'b1);
        run_branch("br_nz_not", 16'h42FE, 1'b0);
        run_branch("br_always", 16'h40FE, 1'b1);

        // ALU with C=0 N=1 Z=0 -> flags 010
        IR = 16'h029D;
        chk("alu2_fetch", e_fetch);
        cyc();
        chk("alu2_decode", e_idle);
        cyc();
        {C, N, Z} = 3'b010;
        chk("alu2_exec", ev(1,3'd2,3'd3,3'd5,0,4'h2,0,0,0,0,0,0,0,0));
        cyc();
        exp_flags = 3'b010;

        run_branch("br_z_not", 16'h41FE, 1'b0);
        run_branch("br_nz_taken", 16'h42FE, 1'b1);
        run_branch("br_c_not", 16'h43FE, 1'b0);
        run_branch("br_nc_taken", 16'h44FE, 1'b1);
        run_branch("br_n_taken", 16'h45FE, 1'b1);
        run_branch("br_nn_not", 16'h46FE, 1'b0);
        run_branch("br_never7", 16'h47FE, 1'b0);
        run_branch("br_neverF", 16'h4FFE, 1'b0);

        // Reset in the middle of an ALU execute aborts the write and flag update
        IR = 16'h029D;
        chk("abort_fetch", e_fetch);
        cyc();
        chk("abort_decode", e_idle);
        cyc();
        {C, N, Z} = 3'b111;
        reset     = 1'b1;
        exp_flags = 3'b000;
        chk("abort_exec", e_idle);
        cyc();
        chk("abort_reset2", e_idle);
        reset = 1'b0;
        chk("abort_refetch", e_fetch);

        // Illegal opcode goes to HALT
        IR = 16'h9000;
        cyc();
        chk("ill_decode", e_idle);
        cyc();
        chk("ill_halt", e_halt);
        cyc();
        chk("ill_halt_hold", e_halt);

        reset = 1'b1;
        cyc();
        chk("ill_reset1", e_idle);
        cyc();
        chk("ill_reset2", e_idle);
        reset = 1'b0;

        // HALT instruction, held for 20 clocks
        IR = 16'hF000;
        chk("halt_fetch", e_fetch);
        cyc();
        chk("halt_decode", e_idle);
        cyc();
        for (int i = 0; i < 20; i++) begin
            chk("halt_hold", e_halt);
            cyc();
        end
        reset = 1'b1;
        cyc();
        chk("halt_reset1", e_idle);
        cyc();
        chk("halt_reset2", e_idle);
        reset = 1'b0;

`ifdef CPU_CU_SINGLE_STEP_EN
        // No step: FETCH waits with all enables low
        step = 1'b0;
        IR   = 16'h029D;
        for (int i = 0; i < 10; i++) begin
            chk("step_wait", e_idle);
            cyc();
        end
        step = 1'b1;
        chk("step_fetch", e_fetch);
        cyc();
        step = 1'b0;
        chk("step_decode", e_idle);
        cyc();
        {C, N, Z} = 3'b100;
        chk("step_exec", ev(1,3'd2,3'd3,3'd5,0,4'h2,0,0,0,0,0,0,0,0));
        cyc();
        exp_flags = 3'b100;
        for (int i = 0; i < 5; i++) begin
            chk("step_idle_after", e_idle);
            cyc();
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
